// File: rtl/fpga_asynch_pkg.sv
// rtl/fpga_asynch_pkg.sv - shared state encodings and parameter bounds for the asynch link endpoint
package fpga_asynch_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int SEND_DELAY_MAX  = 15;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_REQ   = 2'd2,
    TX_REL   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/fpga_asynch_sync.sv
// rtl/fpga_asynch_sync.sv - N-stage async-reset synchroniser for one asynch link input
module fpga_asynch_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_dut_asynch_endpoint.sv
// rtl/fpga_dut_asynch_endpoint.sv - DUT-side four-phase req/ack endpoint; FPGA_DUT_EP_STATS_EN adds transfer counters
module fpga_dut_asynch_endpoint
  import fpga_asynch_pkg::*;
#(
  parameter int MSG_SZ      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SEND_DELAY  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_req,
  input  logic [MSG_SZ-1:0] in_msg,
  output logic              in_ack,
  output logic              core_in_val,
  output logic [MSG_SZ-1:0] core_in_msg,
  input  logic              core_in_rdy,
  input  logic              core_out_val,
  input  logic [MSG_SZ-1:0] core_out_msg,
  output logic              core_out_rdy,
  output logic              out_req,
  output logic [MSG_SZ-1:0] out_msg,
  input  logic              out_ack
`ifdef FPGA_DUT_EP_STATS_EN
  ,
  output logic [15:0]       stat_in_cnt,
  output logic [15:0]       stat_out_cnt
`endif
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
      SEND_DELAY < 0 || SEND_DELAY > SEND_DELAY_MAX) begin : g_bad_param
    $error("fpga_dut_asynch_endpoint: SYNC_STAGES or SEND_DELAY out of range");
  end

  localparam logic [3:0] DLY_LAST = (SEND_DELAY == 0) ? 4'd0 : 4'(SEND_DELAY - 1);

  logic req_s;
  logic ack_s;

  fpga_asynch_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk), .reset_n(reset_n), .d(in_req), .q(req_s)
  );

  fpga_asynch_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .reset_n(reset_n), .d(out_ack), .q(ack_s)
  );

  rx_state_e         rx_q, rx_d;
  logic              full_q, full_d;
  logic [MSG_SZ-1:0] buf_q, buf_d;
  tx_state_e         tx_q, tx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MSG_SZ-1:0] out_msg_q, out_msg_d;
  logic              alive_q, alive_d;

  // Capture needs an empty buffer, so the dequeue clear never collides with it.
  always_comb begin
    rx_d   = rx_q;
    full_d = full_q;
    buf_d  = buf_q;
    if (full_q && core_in_rdy) begin
      full_d = 1'b0;
    end
    unique case (rx_q)
      RX_IDLE: begin
        if (req_s && !full_q) begin
          buf_d  = in_msg;
          full_d = 1'b1;
          rx_d   = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!req_s) begin
          rx_d = RX_IDLE;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // alive_q keeps core_out_rdy low until the first edge after reset release.
  always_comb begin
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    out_msg_d = out_msg_q;
    alive_d   = 1'b1;
    unique case (tx_q)
      TX_IDLE: begin
        if (alive_q && core_out_val) begin
          out_msg_d = core_out_msg;
          cnt_d     = 4'd0;
          tx_d      = (SEND_DELAY == 0) ? TX_REQ : TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (cnt_q == DLY_LAST) begin
          tx_d = TX_REQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      TX_REQ: begin
        if (ack_s) begin
          tx_d = TX_REL;
        end
      end
      TX_REL: begin
        if (!ack_s) begin
          tx_d = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q      <= RX_IDLE;
      full_q    <= 1'b0;
      buf_q     <= '0;
      tx_q      <= TX_IDLE;
      cnt_q     <= 4'd0;
      out_msg_q <= '0;
      alive_q   <= 1'b0;
    end else begin
      rx_q      <= rx_d;
      full_q    <= full_d;
      buf_q     <= buf_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      out_msg_q <= out_msg_d;
      alive_q   <= alive_d;
    end
  end

  assign in_ack       = (rx_q == RX_ACK);
  assign core_in_val  = full_q;
  assign core_in_msg  = buf_q;
  assign core_out_rdy = alive_q && (tx_q == TX_IDLE);
  assign out_req      = (tx_q == TX_REQ);
  assign out_msg      = out_msg_q;

`ifdef FPGA_DUT_EP_STATS_EN
  logic [15:0] stat_in_q, stat_in_d;
  logic [15:0] stat_out_q, stat_out_d;

  always_comb begin
    stat_in_d  = stat_in_q;
    stat_out_d = stat_out_q;
    if (rx_q == RX_IDLE && rx_d == RX_ACK && stat_in_q != 16'hFFFF) begin
      stat_in_d = stat_in_q + 16'd1;
    end
    if (tx_q == TX_REQ && tx_d == TX_REL && stat_out_q != 16'hFFFF) begin
      stat_out_d = stat_out_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_in_q  <= 16'd0;
      stat_out_q <= 16'd0;
    end else begin
      stat_in_q  <= stat_in_d;
      stat_out_q <= stat_out_d;
    end
  end

  assign stat_in_cnt  = stat_in_q;
  assign stat_out_cnt = stat_out_q;
`endif

endmodule
